// File: rtl/tc_hdd_streamer_pkg.sv
// tc_hdd_streamer shared types.
// Controller state encoding and word width.
package tc_hdd_streamer_pkg;

  localparam int TC_WORD_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_READ,
    ST_WRITE,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/tc_hdd_rd_fifo.sv
// Read-return buffer for tc_hdd_streamer.
// Power-of-two deep synchronous FIFO with occupancy count.
module tc_hdd_rd_fifo
  import tc_hdd_streamer_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [TC_WORD_W-1:0] push_data,
  input  logic                 pop,
  output logic [TC_WORD_W-1:0] head,
  output logic [CW-1:0]        count,
  output logic                 empty
);

  logic [TC_WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]        wp;
  logic [AW-1:0]        rp;
  logic                 rd_en;

  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  assign head  = mem[rp];

  // storage write, no reset needed on data
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= push_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)  wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/tc_hdd_streamer.sv
// Absolute-address block streamer for the TC HDD port.
// Turns read/write block commands into relative seek/load/save.
module tc_hdd_streamer
  import tc_hdd_streamer_pkg::*;
#(
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [TC_WORD_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [TC_WORD_W-1:0] rd_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [TC_WORD_W-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [TC_WORD_W-1:0] hdd_seek,
  output logic                 hdd_load,
  output logic                 hdd_save,
  output logic [TC_WORD_W-1:0] hdd_in,
  input  logic [TC_WORD_W-1:0] hdd_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t               state;
  state_t               state_n;
  logic                 wr_q;
  logic [TC_WORD_W-1:0] addr_q;
  logic [TC_WORD_W-1:0] pos;
  logic [LEN_W-1:0]     rem;
  logic [LEN_W-1:0]     rem_n;
  logic                 inflight;
  logic                 done_n;
  logic                 issue;
  logic                 save;
  logic [TC_WORD_W-1:0] seek;
  logic [TC_WORD_W-1:0] wdat;
  logic [CW-1:0]        fcount;
  logic                 fempty;
  logic                 pop;
  logic [CW-1:0]        occ;
  logic                 credit;

  assign rd_valid = ~fempty;
  assign pop      = rd_valid & rd_ready;
  assign busy     = (state != ST_IDLE);

  // a word popped this cycle frees its slot for a new load now
  assign occ    = fcount + CW'(inflight) - CW'(pop);
  assign credit = (occ < CW'(FIFO_DEPTH));

  // the HDD is reset in the same cycle, so keep it quiet
  assign hdd_load = issue & ~rst;
  assign hdd_save = save & ~rst;
  assign hdd_seek = rst ? '0 : seek;
  assign hdd_in   = rst ? '0 : wdat;

  tc_hdd_rd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(hdd_out),
    .pop      (pop),
    .head     (rd_data),
    .count    (fcount),
    .empty    (fempty)
  );

  // next state, HDD strobes and handshake outputs
  always_comb begin
    state_n   = state;
    rem_n     = rem;
    done_n    = 1'b0;
    issue     = 1'b0;
    save      = 1'b0;
    seek      = '0;
    wdat      = '0;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0) done_n  = 1'b1;
          else               state_n = ST_SEEK;
        end
      end
      ST_SEEK: begin
        seek    = addr_q - pos;
        state_n = wr_q ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        if (rem == '0) begin
          state_n = ST_DRAIN;
        end else if (credit) begin
          issue = 1'b1;
          seek  = 64'd1;
          rem_n = rem - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!inflight && fempty) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          save  = 1'b1;
          seek  = 64'd1;
          wdat  = wr_data;
          rem_n = rem - 1'b1;
          if (rem == LEN_W'(1)) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state, command latch and HDD pointer mirror
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      rem      <= '0;
      pos      <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      pos      <= pos + hdd_seek;
      inflight <= issue;
      done     <= done_n;
      if (state == ST_IDLE && cmd_valid) begin
        wr_q   <= cmd_write;
        addr_q <= cmd_addr;
        rem    <= cmd_len;
      end
    end
  end

endmodule

// File: tb/tb_tc_hdd_streamer.sv
// Scoreboard bench for tc_hdd_streamer with a behavioural HDD.
// Reference model: shadow memory, expected-word and seek queues.
`timescale 1ns/1ps
module tb_tc_hdd_streamer;
  import tc_hdd_streamer_pkg::*;

  localparam int LEN_W = 16;
  localparam int DEPTH = 2;
  localparam int M     = 16;
  localparam int AW    = $clog2(M);

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [63:0] cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_data;
  logic        busy;
  logic        done;
  logic [63:0] hdd_seek;
  logic        hdd_load;
  logic        hdd_save;
  logic [63:0] hdd_in;
  logic [63:0] hdd_out;

  tc_hdd_streamer #(
    .LEN_W(LEN_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data),
    .busy(busy), .done(done),
    .hdd_seek(hdd_seek), .hdd_load(hdd_load),
    .hdd_save(hdd_save), .hdd_in(hdd_in),
    .hdd_out(hdd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural TC HDD: relative pointer, 1-cycle load latency
  logic [63:0] hmem [M];
  logic [63:0] hptr;
  bit          hinit = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      hptr <= '0;
      if (!hinit) begin
        for (int k = 0; k < M; k++)
          hmem[k] <= 64'hC0DE_0000_0000_0000 | 64'(k);
        hinit <= 1'b1;
      end
    end else begin
      if (hdd_load) hdd_out <= hmem[hptr[AW-1:0]];
      if (hdd_save) hmem[hptr[AW-1:0]] <= hdd_in;
      hptr <= hptr + hdd_seek;
    end
  end

  int errors = 0;
  int checks = 0;
  logic [63:0] smem [M];
  logic [63:0] mpos;
  logic [63:0] rd_q [$];
  logic [63:0] seek_q [$];
  logic [63:0] rd_log [$];
  logic [63:0] seek_log [$];
  logic [63:0] wfix [$];
  int done_cnt = 0;
  int act_cnt = 0;
  int outstanding = 0;
  int max_out = 0;
  int rd_mode = 0;
  int bp_idx = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // rd_ready driver: 0 always, 1 pattern 1,0,0,1, 2 random, 3 low
  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        0: rd_ready = 1'b1;
        1: begin
          rd_ready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
          bp_idx++;
        end
        2: rd_ready = ($urandom_range(0, 2) != 0);
        default: rd_ready = 1'b0;
      endcase
    end
  end

  // monitor: pops expectations whenever the DUT presents output
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
    end else begin
      if (rd_valid && rd_ready) begin
        rd_log.push_back(rd_data);
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got %h expected none", rd_data);
        end else begin
          chk("rd_data", rd_data, rd_q.pop_front());
        end
      end
      if (hdd_seek != 0 && !hdd_load && !hdd_save) begin
        seek_log.push_back(hdd_seek);
        if (seek_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL seek_unexpected: got %h expected none", hdd_seek);
        end else begin
          chk("seek_delta", hdd_seek, seek_q.pop_front());
        end
      end
      if (hdd_load || hdd_save) chk("strobe_seek", hdd_seek, 64'd1);
      if (hdd_load || hdd_save || hdd_seek != 0) act_cnt++;
      outstanding += int'(hdd_load) - int'(rd_valid && rd_ready);
      if (outstanding > max_out) max_out = outstanding;
      if (done) done_cnt++;
    end
  end

  task automatic do_cmd(input bit w, input logic [63:0] a, input int n);
    int t;
    int d0;
    int i;
    logic [63:0] ai;
    logic [63:0] wd;
    bit acc;
    t = 0;
    while (busy && t < 200) begin @(posedge clk); #1; t++; end
    if (!w)
      for (int k = 0; k < n; k++) begin
        ai = a + 64'(k);
        rd_q.push_back(smem[ai[AW-1:0]]);
      end
    if (n != 0 && (a - mpos) != 0) seek_q.push_back(a - mpos);
    d0 = done_cnt;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = LEN_W'(n);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      chk("len0_done_next", 64'(done), 64'd1);
      @(posedge clk); #1;
    end
    i = 0;
    t = 0;
    while (w && i < n && t < 500) begin
      wd = (wfix.size() != 0) ? wfix[0] : {$urandom, $urandom};
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = wd;
      @(negedge clk);
      acc = wr_valid && wr_ready;
      @(posedge clk); #1;
      t++;
      if (acc) begin
        ai = a + 64'(i);
        smem[ai[AW-1:0]] = wd;
        if (wfix.size() != 0) void'(wfix.pop_front());
        i++;
      end
    end
    wr_valid = 1'b0;
    if (w) chk("wr_words", 64'(i), 64'(n));
    t = 0;
    while (done_cnt == d0 && t < 300) begin @(posedge clk); #1; t++; end
    repeat (2) begin @(posedge clk); #1; end
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    if (n != 0) mpos = a + 64'(n);
    chk("pos", hptr, mpos);
    chk("rd_all_delivered", 64'(rd_q.size()), 64'd0);
  endtask

  logic [63:0] v;
  int a0;
  int d0;
  int t;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    mpos = '0;
    for (int k = 0; k < M; k++)
      smem[k] = 64'hC0DE_0000_0000_0000 | 64'(k);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_strobes", {62'd0, hdd_load, hdd_save}, 64'd0);
    chk("rst_seek", hdd_seek, 64'd0);
    @(posedge clk); #1;

    // write 3 at 5 then read them back
    seek_log.delete();
    rd_log.delete();
    wfix = '{64'hA1, 64'hA2, 64'hA3};
    do_cmd(1'b1, 64'd5, 3);
    do_cmd(1'b0, 64'd5, 3);
    v = (rd_log.size() > 0) ? rd_log[0] : 'x;
    chk("wr_rd_word0", v, 64'hA1);
    v = (rd_log.size() > 1) ? rd_log[1] : 'x;
    chk("wr_rd_word1", v, 64'hA2);
    v = (rd_log.size() > 2) ? rd_log[2] : 'x;
    chk("wr_rd_word2", v, 64'hA3);
    v = (seek_log.size() > 0) ? seek_log[0] : 'x;
    chk("seek_plus5", v, 64'd5);
    v = (seek_log.size() > 1) ? seek_log[1] : 'x;
    chk("seek_minus3", v, 64'hFFFF_FFFF_FFFF_FFFD);

    // backpressure read of 4
    rd_mode = 1;
    bp_idx = 0;
    max_out = 0;
    rd_log.delete();
    do_cmd(1'b0, 64'd3, 4);
    chk("bp_max_outstanding", 64'(max_out <= DEPTH), 64'd1);
    chk("bp_words", 64'(rd_log.size()), 64'd4);
    rd_mode = 0;

    // zero-length command
    a0 = act_cnt;
    do_cmd(1'b0, 64'd100, 0);
    chk("len0_no_activity", 64'(act_cnt - a0), 64'd0);

    // reset in the middle of a read
    rd_mode = 1;
    bp_idx = 0;
    rd_log.delete();
    for (int k = 0; k < 5; k++) rd_q.push_back(smem[9 + k]);
    seek_q.push_back(64'd9 - mpos);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 64'd9;
    cmd_len = LEN_W'(5);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 0;
    while (rd_log.size() < 2 && t < 200) begin @(posedge clk); #1; t++; end
    chk("mid_two_words", 64'(rd_log.size() >= 2), 64'd1);
    rst = 1'b1;
    rd_mode = 3;
    d0 = done_cnt;
    repeat (2) begin @(posedge clk); #1; end
    rd_q.delete();
    seek_q.delete();
    mpos = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_rd_valid", 64'(rd_valid), 64'd0);
    chk("mid_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_done", 64'(done_cnt - d0), 64'd0);
    chk("mid_ptr_zero", hptr, 64'd0);
    rd_mode = 0;
    rd_log.delete();
    do_cmd(1'b0, 64'd0, 1);
    v = (rd_log.size() > 0) ? rd_log[0] : 'x;
    chk("mid_mem0", v, 64'hC0DE_0000_0000_0000);

    // write across the top of the address space
    wfix = '{64'hBEEF_0001, 64'hBEEF_0002};
    do_cmd(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    chk("wrap_top", hmem[M-1], 64'hBEEF_0001);
    chk("wrap_zero", hmem[0], 64'hBEEF_0002);
    chk("wrap_pos", hptr, 64'd1);

    // randomized mix
    rd_mode = 2;
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 3) == 0)
        v = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      else
        v = {$urandom, $urandom};
      do_cmd(bit'($urandom_range(0, 1)), v, $urandom_range(0, 6));
    end
    rd_mode = 0;
    chk("seek_all_seen", 64'(seek_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
